// File: rtl/sub_pkg.sv
// sub_pkg: shared types and elaboration helpers for the digit-serial subtractor.
//   state_t   - controller states (IDLE, RUN)
//   clog2     - ceiling log2, used to size the digit index
//   digits_ok - true when the operand width splits into whole digits
package sub_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

   function automatic bit digits_ok(input int nbits, input int wbits);
      return (wbits > 0) && (nbits >= wbits) && ((nbits % wbits) == 0);
   endfunction

endpackage

// File: rtl/sub_3.sv
// sub_3: combinational subtractor y = a - b - c over NBITS bits.
//   a, b : operands
//   c    : borrow-in
//   y    : difference modulo 2^NBITS
//   cout : borrow-out (1 when a < b + c)
module sub_3 #(
   parameter int NBITS = 8
) (
   input  logic [NBITS-1:0] a,
   input  logic [NBITS-1:0] b,
   input  logic             c,
   output logic             cout,
   output logic [NBITS-1:0] y
);

   // One extra bit on the left catches the borrow as the sign of the result.
   always_comb begin
      {cout, y} = {1'b0, a} - {1'b0, b} - {{NBITS{1'b0}}, c};
   end

endmodule

// File: rtl/sub_serial_cond.sv
// sub_serial_cond: digit-serial subtractor, y = a - b - c, LSB digit first,
// with optional conditional (Montgomery final reduction) mode.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : launch request, accepted only when idle
//   mode       : 0 = y = a - b - c, 1 = y = (a >= b + c) ? a - b - c : a
//   a, b, c    : operands and borrow-in, captured on acceptance
//   busy       : operation in progress
//   done       : one-cycle pulse when y/cout are updated
//   cout       : final borrow (1 means a < b + c)
//   y          : result register
module sub_serial_cond
   import sub_pkg::*;
#(
   parameter int NBITS = 256,
   parameter int WBITS = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [NBITS-1:0] a,
   input  logic [NBITS-1:0] b,
   input  logic             c,
   output logic             busy,
   output logic             done,
   output logic             cout,
   output logic [NBITS-1:0] y
);

   localparam int NDIG = NBITS / WBITS;
   localparam int IW   = (NDIG > 1) ? clog2(NDIG) : 1;
   localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

   if (!digits_ok(NBITS, WBITS)) begin : g_bad_digits
      $error("sub_serial_cond: NBITS must be a whole multiple of WBITS");
   end

   state_t           state;
   state_t           state_next;
   logic [IW-1:0]    idx;
   logic [NBITS-1:0] a_r;
   logic [NBITS-1:0] b_r;
   logic [NBITS-1:0] work;
   logic             mode_r;
   logic             borrow;

   logic             step;
   logic             last;
   logic [IW-1:0]    wr_idx;
   logic [WBITS-1:0] a_dig;
   logic [WBITS-1:0] b_dig;
   logic             b_in;
   logic [WBITS-1:0] diff;
   logic             b_out;
   logic [NBITS-1:0] a_src;
   logic             mode_src;
   logic [NBITS-1:0] y_cat;

   assign busy = (state == RUN);

   // Digit 0 is consumed straight from the ports on the accepting edge, so
   // the last digit lands NDIG edges after start and done follows in cycle NDIG.
   always_comb begin
      state_next = state;
      step       = 1'b0;
      last       = 1'b0;
      wr_idx     = '0;
      a_dig      = a[WBITS-1:0];
      b_dig      = b[WBITS-1:0];
      b_in       = c;
      a_src      = a;
      mode_src   = mode;
      case (state)
         IDLE: begin
            if (start) begin
               step = 1'b1;
               last = (NDIG == 1);
               if (NDIG > 1) state_next = RUN;
            end
         end
         RUN: begin
            step     = 1'b1;
            wr_idx   = idx;
            a_dig    = a_r[idx*WBITS +: WBITS];
            b_dig    = b_r[idx*WBITS +: WBITS];
            b_in     = borrow;
            a_src    = a_r;
            mode_src = mode_r;
            last     = (idx == LAST);
            if (last) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   sub_3 #(.NBITS(WBITS)) u_digit (
      .a    (a_dig),
      .b    (b_dig),
      .c    (b_in),
      .cout (b_out),
      .y    (diff)
   );

   // Full result: finished lower digits from the working register, top digit live.
   always_comb begin
      y_cat = work;
      y_cat[NBITS-1 -: WBITS] = diff;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx    <= '0;
         a_r    <= '0;
         b_r    <= '0;
         mode_r <= 1'b0;
         work   <= '0;
         borrow <= 1'b0;
         done   <= 1'b0;
         cout   <= 1'b0;
         y      <= '0;
      end else begin
         done <= 1'b0;
         if (state == IDLE && start) begin
            a_r    <= a;
            b_r    <= b;
            mode_r <= mode;
         end
         if (step) begin
            work[wr_idx*WBITS +: WBITS] <= diff;
            borrow <= b_out;
            idx    <= wr_idx + IW'(1);
            if (last) begin
               cout <= b_out;
               y    <= (mode_src && b_out) ? a_src : y_cat;
               done <= 1'b1;
               idx  <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_sub_serial_cond.sv
// tb_sub_serial_cond: self-checking bench for sub_serial_cond (NBITS=16, WBITS=4).
// Inputs are driven and outputs sampled on the falling edge; expected results
// come from integer arithmetic on whole operands.
module tb_sub_serial_cond;

   localparam int NBITS = 16;
   localparam int WBITS = 4;
   localparam int NDIG  = NBITS / WBITS;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             mode;
   logic [NBITS-1:0] a;
   logic [NBITS-1:0] b;
   logic             c;
   logic             busy;
   logic             done;
   logic             cout;
   logic [NBITS-1:0] y;

   int               n_checks;
   int               n_errors;
   logic [NBITS-1:0] last_y;
   logic             last_c;

   sub_serial_cond #(.NBITS(NBITS), .WBITS(WBITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .mode  (mode),
      .a     (a),
      .b     (b),
      .c     (c),
      .busy  (busy),
      .done  (done),
      .cout  (cout),
      .y     (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void ref_sub(input logic [NBITS-1:0] ta, input logic [NBITS-1:0] tb,
                                   input logic tc, input logic tm,
                                   output logic [NBITS-1:0] ry, output logic rc);
      int d;
      d  = int'(ta) - int'(tb) - int'(tc);
      rc = (d < 0);
      ry = (tm && rc) ? ta : NBITS'(d);
   endfunction

   // One idle cycle: no done, result held.
   task automatic idle_cycle(input string tag);
      @(negedge clk);
      check({tag, ".done"}, 32'(done), 32'd0);
      check({tag, ".y"}, 32'(y), 32'(last_y));
   endtask

   // Launch in the current cycle (cycle 0) and check every cycle up to and
   // including the done cycle (cycle NDIG), where the task returns.
   // restart_k > 0 raises a spurious start with other operands in that cycle.
   task automatic op(input logic [NBITS-1:0] ta, input logic [NBITS-1:0] tb,
                     input logic tc, input logic tm, input int restart_k, input string tag);
      logic [NBITS-1:0] ey;
      logic             ec;
      ref_sub(ta, tb, tc, tm, ey, ec);
      a = ta; b = tb; c = tc; mode = tm; start = 1'b1;
      for (int k = 1; k <= NDIG; k++) begin
         @(negedge clk);
         if (k < NDIG) begin
            check({tag, ".busy"}, 32'(busy), 32'd1);
            check({tag, ".done_early"}, 32'(done), 32'd0);
            check({tag, ".y_hold"}, 32'(y), 32'(last_y));
            check({tag, ".cout_hold"}, 32'(cout), 32'(last_c));
         end else begin
            check({tag, ".done"}, 32'(done), 32'd1);
            check({tag, ".busy_end"}, 32'(busy), 32'd0);
            check({tag, ".y"}, 32'(y), 32'(ey));
            check({tag, ".cout"}, 32'(cout), 32'(ec));
         end
         // Operands may move freely once accepted.
         start = (k == restart_k);
         a = NBITS'($urandom); b = NBITS'($urandom);
         c = 1'($urandom); mode = 1'($urandom);
      end
      last_y = ey;
      last_c = ec;
   endtask

   typedef struct {
      logic [NBITS-1:0] a;
      logic [NBITS-1:0] b;
      logic             c;
      logic             m;
   } vec_t;

   vec_t vecs[6];

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0; c = 1'b0;
      vecs[0] = '{16'h1234, 16'h0234, 1'b0, 1'b0};
      vecs[1] = '{16'h1000, 16'h0001, 1'b0, 1'b0};
      vecs[2] = '{16'h0001, 16'h0002, 1'b0, 1'b0};
      vecs[3] = '{16'h0001, 16'h0002, 1'b0, 1'b1};
      vecs[4] = '{16'hFFFF, 16'h0001, 1'b1, 1'b1};
      vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b1};

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.done", 32'(done), 32'd0);
      check("rst.cout", 32'(cout), 32'd0);
      check("rst.y", 32'(y), 32'd0);
      rst_n  = 1'b1;
      last_y = '0;
      last_c = 1'b0;
      idle_cycle("idle0");

      // Directed cases, each separated by an idle cycle.
      foreach (vecs[i]) begin
         op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].m, 0, $sformatf("dir%0d", i));
         idle_cycle($sformatf("dir%0d.after", i));
      end

      // Spurious start in cycle 2 is ignored: single done in cycle 4, none after.
      op(16'h5555, 16'h1111, 1'b0, 1'b0, 2, "ign");
      for (int k = 0; k < NDIG + 1; k++) idle_cycle("ign.after");

      // Back-to-back: second start in the done cycle, next done in cycle 8.
      op(16'h0F0F, 16'h00FF, 1'b1, 1'b0, 0, "b2b0");
      op(16'h0003, 16'h0004, 1'b0, 1'b1, 0, "b2b1");
      idle_cycle("b2b.after");

      // Randomized operations, mixing idle gaps and back-to-back launches.
      for (int n = 0; n < 40; n++) begin
         logic [NBITS-1:0] ra;
         logic [NBITS-1:0] rb;
         ra = NBITS'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? ra : NBITS'($urandom);
         op(ra, rb, 1'($urandom), 1'($urandom), 0, $sformatf("rnd%0d", n));
         if ($urandom_range(0, 1) == 1) idle_cycle("rnd.gap");
      end
      idle_cycle("rnd.end");

      // Reset at the edge ending cycle 2 aborts the operation.
      a = 16'h4321; b = 16'h0021; c = 1'b0; mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("abort.busy1", 32'(busy), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort.busy", 32'(busy), 32'd0);
      check("abort.y", 32'(y), 32'd0);
      check("abort.cout", 32'(cout), 32'd0);
      last_y = '0;
      last_c = 1'b0;
      for (int k = 0; k < NDIG + 2; k++) idle_cycle("abort.after");

      // Recovery after the abort.
      op(16'h0100, 16'h0001, 1'b0, 1'b0, 0, "recover");
      idle_cycle("recover.after");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
